icache_sa: RTL and testbench
============================

# icache_sa

Parametrised set-associative instruction cache between the IFU fetch port and the AXI read master. It is the successor to the fixed 4 KB icache.
- Set count, way count and block size are generics.
- Adds a complete miss-refill state machine, per-set round-robin replacement, `fence_i` invalidation and AXI error reporting.
- Refill uses sequential single-beat 32-bit AXI reads.
- Data and tag arrays are internal flops, so there are no external SRAM ports.

## Interface
Parameters:
- `NSET`, 32: number of sets, power of two, ≥2.
- `NWAY`, 8: ways per set, power of two, ≥2.
- `BLOCK_BYTES`, 16: line size, power of two, ≥4.
- Derived, not overridable: `OFF_W=log2(BLOCK_BYTES)`, `IDX_W=log2(NSET)`, `TAG_W=32-IDX_W-OFF_W`, `BEATS=BLOCK_BYTES/4`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets all state immediately.
- `arvalid` in 1: fetch request valid.
- `arready` out 1: cache accepts request.
- `addr_i` in 32: fetch address; bits [1:0] ignored.
- `rvalid` out 1: response valid.
- `rready` in 1: IFU accepts response.
- `data_o` out 32: instruction word.
- `rerr` out 1: response carries an AXI error; `data_o` undefined.
- `fence_i` in 1: invalidate all lines.
- `axi_arvalid` out 1, `axi_arready` in 1, `axi_araddr` out 32.
- `axi_rvalid` in 1, `axi_rready` out 1, `axi_rdata` in 32, `axi_rresp` in 2.

## Operation
State machine: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.

- **IDLE**
  - `arready=1` unless `fence_i=1`.
  - `fence_i` has priority: all valid bits clear at the next edge, no request is accepted that cycle, state stays IDLE.
  - On `arvalid&&arready`: latch `addr_i` into `req_addr`, go to LOOKUP.
- **LOOKUP**
  - idx = `req_addr[OFF_W+IDX_W-1:OFF_W]`, tag = `req_addr[31:OFF_W+IDX_W]`.
  - Hit when any way has valid=1 and a matching tag. At most one way can match.
  - Hit: select word `req_addr[OFF_W-1:2]`, register into `data_o`, go to RESP, advance that set's replacement pointer only if the hit way equals the pointer (this keeps the victim fresh).
  - Miss: victim = first invalid way (lowest index) if any, else the set's round-robin pointer. Clear the beat counter, go to MISS_AR.
- **MISS_AR**
  - `axi_arvalid=1`, `axi_araddr = {req_addr[31:OFF_W], beat, 2'b00}`.
  - Address is stable until `axi_arready`; on the handshake go to MISS_R.
- **MISS_R**
  - `axi_rready=1`. On `axi_rvalid`, write `axi_rdata` into the victim line word `beat` and record an error if `axi_rresp!=0`.
  - Beat == requested word: capture it into `data_o`.
  - Last beat (`beat==BEATS-1`): if no error in any beat, set tag and valid and advance the pointer to victim+1 mod `NWAY`; if any error, leave valid=0. Go to RESP.
  - Otherwise `beat++` and go to MISS_AR.
- **RESP**
  - `rvalid=1`; `rerr` = sticky error flag.
  - Hold `data_o`/`rerr` until `rready`, then go to IDLE and clear the error flag.

Other rules:
- `fence_i` outside IDLE is ignored. The IFU holds it until it observes `arready`.
- Replacement pointers reset to 0. All valid bits reset to 0. Data and tag arrays have no reset.

## Timing
- All outputs are 0 in reset: `arready`, `rvalid`, `rerr`, `data_o`, `axi_arvalid`, `axi_rready`, `axi_araddr`.
- Hit latency: request handshake at edge N gives `rvalid` high in cycle N+2 (LOOKUP is cycle N+1).
- Miss latency: 2 + `BEATS`×(AR wait + 1 + R wait + 1) cycles from handshake to `rvalid`.
- Exactly one outstanding AXI read at a time. The requested word is never forwarded early.
- Reset asserted mid-refill: `axi_arvalid`/`axi_rready` drop asynchronously; the partially filled line stays invalid; any in-flight AXI beat is the interconnect's concern.
- `arvalid` and `fence_i` in the same IDLE cycle: only the fence is taken; the request is accepted next cycle.

## Structure
- Package `icache_pkg`: `NSET`/`NWAY`/`BLOCK_BYTES` defaults, state enum (IDLE..RESP), `AXI_RESP_OKAY=2'b00`, and the log2 helper used for derived widths.
- Sub-module `icache_rr_replacer`: holds `NSET`×`log2(NWAY)` pointers, provides a victim read by idx and an update port (idx, way, en). It is the only replacement logic.
- Top module holds the tag/valid/data arrays, the FSM, the beat counter and the AXI drive.

## Test plan
All cases use `NSET=16`, `NWAY=4`, `BLOCK_BYTES=16`.
1. **Cold miss.** Fetch 0x8000_0004 with a 1-cycle AXI slave.
   - Required: AR addresses 0x8000_0000, …04, …08, …0C in order; `data_o` = word at …04; `rerr=0`.
2. **Hit after fill.** Fetch 0x8000_0008 after case 1.
   - Required: `rvalid` 2 cycles after the handshake, correct word, no `axi_arvalid` activity.
3. **Round-robin eviction.** Fill five lines mapping to set 0 with tags 1..5, then re-fetch tag 1.
   - Required: the tag-5 fill lands in way 0; the tag-1 re-fetch misses and refills into way 1.
4. **AXI error.** `axi_rresp=2'b10` on beat 2 of a refill.
   - Required: all 4 beats complete; response has `rerr=1`; repeating the fetch misses again.
5. **fence_i.** After case 2, pulse `fence_i` in IDLE together with `arvalid`.
   - Required: `arready=0` that cycle; the next fetch of 0x8000_0008 misses.
6. **Reset mid-refill.** Assert `reset=0` during MISS_R beat 1, then release.
   - Required: `axi_arvalid`/`axi_rready`/`rvalid` drop immediately; the next fetch to the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the set-associative instruction cache:
//   - default geometry (sets, ways, line size)
//   - controller state encoding
//   - AXI response code for a good beat
//   - log2 helper used to size indices and counters
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int NSET_DEFAULT        = 32;
    localparam int NWAY_DEFAULT        = 8;
    localparam int BLOCK_BYTES_DEFAULT = 16;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        MISS_R,
        RESP
    } state_e;

    // Ceiling log2. Callers only pass powers of two, so this is exact there.
    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/icache_rr_replacer.sv
// -----------------------------------------------------------------------------
// icache_rr_replacer
// One round-robin pointer per set. The pointer names the way that will be
// evicted when a set has no invalid way.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   rd_idx_i           set whose pointer is read
//   victim_o           current pointer of set rd_idx_i
//   upd_en_i           write enable for the update port
//   upd_idx_i          set to update
//   upd_way_i          way just used; pointer becomes upd_way_i + 1 (mod NWAY)
// -----------------------------------------------------------------------------
module icache_rr_replacer
    import icache_pkg::*;
#(
    parameter int NSET = NSET_DEFAULT,
    parameter int NWAY = NWAY_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [log2(NSET)-1:0]   rd_idx_i,
    output logic [log2(NWAY)-1:0]   victim_o,
    input  logic                    upd_en_i,
    input  logic [log2(NSET)-1:0]   upd_idx_i,
    input  logic [log2(NWAY)-1:0]   upd_way_i
);
    localparam int WAY_W = log2(NWAY);

    logic [NSET-1:0][WAY_W-1:0] ptr_q;

    assign victim_o = ptr_q[rd_idx_i];

    // NWAY is a power of two, so the natural wrap of WAY_W bits is the modulo.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (upd_en_i) begin
            ptr_q[upd_idx_i] <= upd_way_i + WAY_W'(1);
        end
    end

endmodule

// File: rtl/icache_sa.sv
// -----------------------------------------------------------------------------
// icache_sa
// Set-associative instruction cache between the IFU fetch port and an AXI
// read master. Misses refill the whole line with single-beat 32-bit reads,
// one outstanding read at a time. Tags, valid bits and data live in flops.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   arvalid/arready       fetch request handshake, addr_i = fetch address
//   rvalid/rready         fetch response handshake, data_o = instruction,
//                         rerr = some refill beat returned an AXI error
//   fence_i               invalidate every line (honoured only in IDLE)
//   axi_ar*/axi_r*        AXI read address / read data channels
// -----------------------------------------------------------------------------
module icache_sa
    import icache_pkg::*;
#(
    parameter int NSET        = NSET_DEFAULT,
    parameter int NWAY        = NWAY_DEFAULT,
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] addr_i,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] data_o,
    output logic        rerr,
    input  logic        fence_i,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp
);
    localparam int OFF_W  = log2(BLOCK_BYTES);
    localparam int IDX_W  = log2(NSET);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int BEATS  = BLOCK_BYTES / 4;
    localparam int WAY_W  = log2(NWAY);
    localparam int BEAT_W = (BEATS > 1) ? log2(BEATS) : 1;

    state_e                    state_q;
    logic [31:0]               req_addr_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [WAY_W-1:0]          victim_q;
    logic                      err_q;
    logic [31:0]               word_q;
    logic [NSET-1:0][NWAY-1:0] valid_q;

    // NOTE: tag and data arrays carry no reset; a line is only ever read
    // after its valid bit is set, and valid bits are reset.
    logic [TAG_W-1:0]          tag_mem  [NSET][NWAY];
    logic [31:0]               data_mem [NSET][NWAY][BEATS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [BEAT_W-1:0] word_sel;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_inv;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  rr_victim;
    logic [WAY_W-1:0]  miss_victim;
    logic              rd_fire;
    logic              last_beat;
    logic              fill_err;
    logic              rr_upd_en;
    logic [WAY_W-1:0]  rr_upd_way;

    assign idx       = req_addr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag       = req_addr_q[31:OFF_W+IDX_W];
    assign word_sel  = BEAT_W'(req_addr_q[OFF_W-1:0] >> 2);
    assign rd_fire   = (state_q == MISS_R) && axi_rvalid;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign fill_err  = err_q || (axi_rresp != AXI_RESP_OKAY);

    // Tag compare across the set; the descending scan leaves the lowest
    // invalid way in inv_way.
    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths where the loop assigns nothing.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign miss_victim = has_inv ? inv_way : rr_victim;

    // A hit on the pointed-at way moves the pointer on so the next victim is
    // not the line just used; a clean fill moves it past the filled way.
    assign rr_upd_en  = ((state_q == LOOKUP) && hit && (hit_way == rr_victim))
                     || (rd_fire && last_beat && !fill_err);
    assign rr_upd_way = (state_q == LOOKUP) ? hit_way : victim_q;

    icache_rr_replacer #(
        .NSET (NSET),
        .NWAY (NWAY)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .rd_idx_i  (idx),
        .victim_o  (rr_victim),
        .upd_en_i  (rr_upd_en),
        .upd_idx_i (idx),
        .upd_way_i (rr_upd_way)
    );

    // Controller. The victim's valid bit drops as soon as the refill starts,
    // so a partly written or errored line can never hit.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            beat_q     <= '0;
            victim_q   <= '0;
            err_q      <= 1'b0;
            word_q     <= '0;
            valid_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fence_i) begin
                        valid_q <= '0;
                    end else if (arvalid) begin
                        req_addr_q <= addr_i;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        word_q  <= data_mem[idx][hit_way][word_sel];
                        state_q <= RESP;
                    end else begin
                        victim_q                  <= miss_victim;
                        valid_q[idx][miss_victim] <= 1'b0;
                        beat_q                    <= '0;
                        state_q                   <= MISS_AR;
                    end
                end
                MISS_AR: begin
                    if (axi_arready) state_q <= MISS_R;
                end
                MISS_R: begin
                    if (axi_rvalid) begin
                        if (axi_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
                        if (beat_q == word_sel) word_q <= axi_rdata;
                        if (last_beat) begin
                            if (!fill_err) valid_q[idx][victim_q] <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            beat_q  <= beat_q + BEAT_W'(1);
                            state_q <= MISS_AR;
                        end
                    end
                end
                RESP: begin
                    if (rready) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rd_fire) begin
            data_mem[idx][victim_q][beat_q] <= axi_rdata;
            if (last_beat) tag_mem[idx][victim_q] <= tag;
        end
    end

    // reset is folded into arready so it reads 0 while reset is held even
    // though the state register sits in IDLE.
    assign arready     = reset && (state_q == IDLE) && !fence_i;
    assign rvalid      = (state_q == RESP);
    assign rerr        = (state_q == RESP) && err_q;
    assign data_o      = word_q;
    assign axi_arvalid = (state_q == MISS_AR);
    assign axi_rready  = (state_q == MISS_R);
    assign axi_araddr  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}} | (32'(beat_q) << 2);

endmodule

// File: tb/tb_icache_sa.sv
// -----------------------------------------------------------------------------
// tb_icache_sa
// Self-checking bench for icache_sa (16 sets, 4 ways, 16-byte lines).
// A behavioural cache model (per-set valid/tag tables and pointers) predicts
// hit/miss, refill addresses, latency, data and error for every fetch; one
// monitor compares the DUT against it each cycle. A simple AXI slave returns
// a fixed function of the address with programmable waits and error beats.
// -----------------------------------------------------------------------------
module tb_icache_sa;
    localparam int NS    = 16;
    localparam int NW    = 4;
    localparam int BEATS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid;
    logic        arready;
    logic [31:0] addr_i;
    logic        rvalid;
    logic        rready;
    logic [31:0] data_o;
    logic        rerr;
    logic        fence_i;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    always #5 clock = ~clock;

    icache_sa #(
        .NSET        (NS),
        .NWAY        (NW),
        .BLOCK_BYTES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .arvalid     (arvalid),
        .arready     (arready),
        .addr_i      (addr_i),
        .rvalid      (rvalid),
        .rready      (rready),
        .data_o      (data_o),
        .rerr        (rerr),
        .fence_i     (fence_i),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int cur_ar_wait  = 0;
    int cur_r_wait   = 0;
    int cur_err_beat = -1;
    bit rready_rand  = 1'b0;

    logic [31:0] ar_exp[$];
    logic [31:0] ar_log[$];

    bit          exp_pending = 1'b0;
    bit          first_seen  = 1'b0;
    logic [31:0] exp_data;
    bit          exp_rerr;
    int          exp_lat;
    int          exp_h;
    int          last_lat  = 0;
    bit          last_rerr = 1'b0;

    // Behavioural cache state
    bit mv   [NS][NW];
    int mt   [NS][NW];
    int mptr [NS];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
        end
    endtask

    task automatic model_fence();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
    endtask

    // Lookup and replacement straight from the cache rules.
    task automatic predict(input logic [31:0] a, input int inj, output bit hit, output int way);
        int idx;
        int tag;
        idx = int'((a >> 4) % NS);
        tag = int'(a >> 8);
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < NW; w++)
            if (mv[idx][w] && mt[idx][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        if (hit) begin
            if (way == mptr[idx]) mptr[idx] = (way + 1) % NW;
            return;
        end
        for (int w = NW - 1; w >= 0; w--)
            if (!mv[idx][w]) way = w;
        if (way < 0) way = mptr[idx];
        mv[idx][way] = 1'b0;
        if (inj < 0) begin
            mv[idx][way] = 1'b1;
            mt[idx][way] = tag;
            mptr[idx]    = (way + 1) % NW;
        end
    endtask

    task automatic issue(input logic [31:0] a, input int inj, input bit with_fence,
                         output bit hit, output int way);
        int n;
        n = 0;
        @(negedge clock);
        addr_i  = a;
        arvalid = 1'b1;
        fence_i = with_fence;
        #1;
        if (with_fence) begin
            check("arready_with_fence", {31'd0, arready}, 32'd0);
            @(negedge clock);
            fence_i = 1'b0;
            model_fence();
            #1;
        end
        while (!arready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!arready) begin
            check("arready_timeout", {31'd0, arready}, 32'd1);
            arvalid = 1'b0;
            hit     = 1'b0;
            way     = -1;
            return;
        end
        predict(a, inj, hit, way);
        cur_err_beat = hit ? -1 : inj;
        if (!hit)
            for (int b = 0; b < BEATS; b++) ar_exp.push_back({a[31:4], 4'h0} + 32'(4 * b));
        exp_data    = mem_word(a);
        exp_rerr    = !hit && (inj >= 0);
        exp_lat     = hit ? 2 : 2 + BEATS * (cur_ar_wait + 1 + cur_r_wait + 1);
        exp_h       = cyc + 1;
        first_seen  = 1'b0;
        exp_pending = 1'b1;
        @(posedge clock);
        #1;
        arvalid = 1'b0;
        addr_i  = $urandom;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_pending && n < 400) begin
            @(negedge clock);
            #3;
            n++;
        end
        if (exp_pending) begin
            check("resp_timeout", {31'd0, rvalid}, 32'd1);
            exp_pending = 1'b0;
        end
        check("ar_outstanding", ar_exp.size(), 32'd0);
        ar_exp.delete();
    endtask

    task automatic fetch(input logic [31:0] a, input int inj, input bit with_fence,
                         output bit hit, output int way);
        issue(a, inj, with_fence, hit, way);
        wait_resp();
    endtask

    task automatic do_fence();
        @(negedge clock);
        fence_i = 1'b1;
        #1;
        check("arready_fence", {31'd0, arready}, 32'd0);
        @(negedge clock);
        fence_i = 1'b0;
        model_fence();
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rready = rready_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    // AXI read slave: one address, then one data beat, per transaction.
    initial begin
        logic [31:0] a;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        forever begin
            if (axi_arvalid === 1'b1 && reset === 1'b1) begin
                repeat (cur_ar_wait) @(negedge clock);
                a           = axi_araddr;
                axi_arready = 1'b1;
                @(negedge clock);
                axi_arready = 1'b0;
                repeat (cur_r_wait) @(negedge clock);
                axi_rvalid = 1'b1;
                axi_rdata  = mem_word(a);
                axi_rresp  = (int'(a[3:2]) == cur_err_beat) ? 2'b10 : 2'b00;
                @(negedge clock);
                axi_rvalid = 1'b0;
                axi_rresp  = 2'b00;
                axi_rdata  = '0;
            end else begin
                @(negedge clock);
            end
        end
    end

    // Compare process: refill addresses, response timing, data and error.
    initial forever begin
        @(negedge clock);
        #2;
        if (reset) begin
            if (axi_arvalid) begin
                if (ar_exp.size() == 0) begin
                    check("ar_unexpected", {31'd0, axi_arvalid}, 32'd0);
                end else begin
                    check("axi_araddr", axi_araddr, ar_exp[0]);
                    if (axi_arready) void'(ar_exp.pop_front());
                end
                if (axi_arready) ar_log.push_back(axi_araddr);
            end
            if (rvalid) begin
                if (!exp_pending) begin
                    check("rvalid_unexpected", {31'd0, rvalid}, 32'd0);
                end else begin
                    if (!first_seen) begin
                        last_lat = cyc - exp_h + 1;
                        check("latency", last_lat, exp_lat);
                        first_seen = 1'b1;
                    end
                    check("rerr", {31'd0, rerr}, {31'd0, exp_rerr});
                    if (!exp_rerr) check("data_o", data_o, exp_data);
                    if (rready) begin
                        last_rerr   = rerr;
                        exp_pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bit          hit;
        int          way;
        int          base;
        int          n;
        int          inj;
        logic [31:0] a;

        reset   = 1'b0;
        arvalid = 1'b0;
        addr_i  = '0;
        fence_i = 1'b0;
        model_clear();
        #3;
        check("rst_arready",     {31'd0, arready},     32'd0);
        check("rst_rvalid",      {31'd0, rvalid},      32'd0);
        check("rst_rerr",        {31'd0, rerr},        32'd0);
        check("rst_data_o",      data_o,               32'd0);
        check("rst_axi_arvalid", {31'd0, axi_arvalid}, 32'd0);
        check("rst_axi_rready",  {31'd0, axi_rready},  32'd0);
        check("rst_axi_araddr",  axi_araddr,           32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Cold miss with a 1-cycle slave
        base = ar_log.size();
        fetch(32'h8000_0004, -1, 1'b0, hit, way);
        check("c1_model_miss", {31'd0, hit}, 32'd0);
        check("c1_ar_count", ar_log.size() - base, 32'd4);
        if (ar_log.size() >= base + 4) begin
            check("c1_ar0", ar_log[base + 0], 32'h8000_0000);
            check("c1_ar1", ar_log[base + 1], 32'h8000_0004);
            check("c1_ar2", ar_log[base + 2], 32'h8000_0008);
            check("c1_ar3", ar_log[base + 3], 32'h8000_000C);
        end
        check("c1_latency", last_lat, 32'd10);
        check("c1_rerr", {31'd0, last_rerr}, 32'd0);

        // Hit after fill
        base = ar_log.size();
        fetch(32'h8000_0008, -1, 1'b0, hit, way);
        check("c2_model_hit", {31'd0, hit}, 32'd1);
        check("c2_ar_count", ar_log.size() - base, 32'd0);
        check("c2_latency", last_lat, 32'd2);

        // fence_i together with arvalid: request taken a cycle later, misses
        base = ar_log.size();
        fetch(32'h8000_0008, -1, 1'b1, hit, way);
        check("c5_ar_count", ar_log.size() - base, 32'd4);

        // Round-robin eviction in set 0
        do_fence();
        for (int t = 1; t <= 5; t++) fetch(32'(t) << 8, -1, 1'b0, hit, way);
        check("c3_tag5_way", way, 32'd0);
        base = ar_log.size();
        fetch(32'h0000_0100, -1, 1'b0, hit, way);
        check("c3_tag1_way", way, 32'd1);
        check("c3_tag1_ar_count", ar_log.size() - base, 32'd4);
        base = ar_log.size();
        fetch(32'h0000_0300, -1, 1'b0, hit, way);
        check("c3_tag3_ar_count", ar_log.size() - base, 32'd0);
        base = ar_log.size();
        fetch(32'h0000_0200, -1, 1'b0, hit, way);
        check("c3_tag2_ar_count", ar_log.size() - base, 32'd4);

        // AXI error on beat 2, then the same fetch must miss again
        cur_ar_wait = 1;
        cur_r_wait  = 1;
        base = ar_log.size();
        fetch(32'h8000_0144, 2, 1'b0, hit, way);
        check("c4_ar_count", ar_log.size() - base, 32'd4);
        check("c4_rerr", {31'd0, last_rerr}, 32'd1);
        check("c4_latency", last_lat, 32'd18);
        base = ar_log.size();
        fetch(32'h8000_0144, -1, 1'b0, hit, way);
        check("c4_refetch_ar_count", ar_log.size() - base, 32'd4);
        check("c4_refetch_rerr", {31'd0, last_rerr}, 32'd0);

        // Reset during the second refill beat
        cur_ar_wait = 0;
        cur_r_wait  = 4;
        base = ar_log.size();
        issue(32'h8000_0248, -1, 1'b0, hit, way);
        n = 0;
        while (ar_log.size() < base + 2 && n < 200) begin
            @(negedge clock);
            #3;
            n++;
        end
        check("c6_reach_beat1", ar_log.size() - base, 32'd2);
        @(negedge clock);
        #1;
        check("c6_in_miss_r", {31'd0, axi_rready}, 32'd1);
        reset = 1'b0;
        #1;
        check("c6_axi_arvalid", {31'd0, axi_arvalid}, 32'd0);
        check("c6_axi_rready",  {31'd0, axi_rready},  32'd0);
        check("c6_rvalid",      {31'd0, rvalid},      32'd0);
        check("c6_arready",     {31'd0, arready},     32'd0);
        exp_pending = 1'b0;
        ar_exp.delete();
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        cur_r_wait = 0;
        base = ar_log.size();
        fetch(32'h8000_0248, -1, 1'b0, hit, way);
        check("c6_refetch_ar_count", ar_log.size() - base, 32'd4);

        // Randomised traffic over a few sets with more tags than ways
        rready_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cur_ar_wait = $urandom_range(0, 2);
            cur_r_wait  = $urandom_range(0, 2);
            if ($urandom_range(0, 29) == 0) do_fence();
            a = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
            inj = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, inj, ($urandom_range(0, 29) == 0), hit, way);
        end

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
